// File: rtl/press_counter_pkg.sv
// Shared constants and the 7-segment decoder for the press counter display.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Segment codes are active-high, bit order {g,f,e,d,c,b,a}.
// The top level applies the board polarity to these codes.
package press_counter_pkg;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Any input above 9 decodes to a dark digit.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = SEG_0;
            4'd1:    seg_decode = SEG_1;
            4'd2:    seg_decode = SEG_2;
            4'd3:    seg_decode = SEG_3;
            4'd4:    seg_decode = SEG_4;
            4'd5:    seg_decode = SEG_5;
            4'd6:    seg_decode = SEG_6;
            4'd7:    seg_decode = SEG_7;
            4'd8:    seg_decode = SEG_8;
            4'd9:    seg_decode = SEG_9;
            default: seg_decode = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/press_counter_display_bcd_digit.sv
// One BCD decade of the up/down press counter.
// Latency: 1 cycle from up/dn and cin/bin to q.
// Backpressure: none; carry/borrow are combinational ripple outputs.
//
// Ports:
//   clkDiv190  clock, posedge
//   rst        synchronous active-high reset
//   clr        synchronous clear to 0
//   up, dn     decoded count direction (mutually exclusive)
//   cin, bin   carry/borrow from the next lower digit
//   q          digit value, always 0..9
//   cout, bout carry/borrow into the next higher digit
module bcd_digit
    import press_counter_pkg::*;
(
    input  logic       clkDiv190,
    input  logic       rst,
    input  logic       clr,
    input  logic       up,
    input  logic       dn,
    input  logic       cin,
    input  logic       bin,
    output logic [3:0] q,
    output logic       cout,
    output logic       bout
);

    logic [3:0] r_q;

    assign q    = r_q;
    assign cout = up & cin & (r_q == BCD_MAX_DIGIT);
    assign bout = dn & bin & (r_q == 4'd0);

    always_ff @(posedge clkDiv190) begin
        if (rst || clr) begin
            r_q <= 4'd0;
        end else if (up && cin) begin
            r_q <= (r_q == BCD_MAX_DIGIT) ? 4'd0 : r_q + 4'd1;
        end else if (dn && bin) begin
            r_q <= (r_q == 4'd0) ? BCD_MAX_DIGIT : r_q - 4'd1;
        end
    end

endmodule

// File: rtl/press_counter_display.sv
// Debounced press pulses drive a NDIG-digit BCD up/down counter shown on a multiplexed 7-seg display.
// Latency: 1 cycle pulse->bcd/wrap; 1 cycle scan index/bcd->an/seg.
// Backpressure: none; every pulse is consumed in the cycle it arrives.
//
// Ports:
//   clkDiv190  display/debounce clock, posedge
//   rst        synchronous active-high reset, highest priority
//   inc_p, dec_p, clr_p  one-cycle pulses; clr wins, inc+dec together holds
//   bcd        count, digit i at bcd[4i+3:4i]
//   an, seg    anode enables and {g,f,e,d,c,b,a}, polarity set by SEG_ACT_LOW
//   wrap       one-cycle flag when the count rolled over in either direction
//
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits
// (units digit is always shown).
module press_counter_display
    import press_counter_pkg::*;
#(
    parameter int NDIG        = 4,
    parameter bit SEG_ACT_LOW = 1'b1
) (
    input  logic              clkDiv190,
    input  logic              rst,
    input  logic              inc_p,
    input  logic              dec_p,
    input  logic              clr_p,
    output logic [4*NDIG-1:0] bcd,
    output logic [NDIG-1:0]   an,
    output logic [6:0]        seg,
    output logic              wrap
);

    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic            w_up;
    logic            w_dn;
    logic [NDIG-1:0] w_cin;
    logic [NDIG-1:0] w_bin;
    logic [NDIG-1:0] w_cout;
    logic [NDIG-1:0] w_bout;

    // clr dominates; inc and dec together cancel out.
    assign w_up = inc_p & ~dec_p & ~clr_p;
    assign w_dn = dec_p & ~inc_p & ~clr_p;

    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_digit
            if (gi == 0) begin : g_lsd
                assign w_cin[gi] = w_up;
                assign w_bin[gi] = w_dn;
            end else begin : g_upper
                assign w_cin[gi] = w_cout[gi-1];
                assign w_bin[gi] = w_bout[gi-1];
            end

            bcd_digit u_digit (
                .clkDiv190 (clkDiv190),
                .rst       (rst),
                .clr       (clr_p),
                .up        (w_up),
                .dn        (w_dn),
                .cin       (w_cin[gi]),
                .bin       (w_bin[gi]),
                .q         (bcd[4*gi +: 4]),
                .cout      (w_cout[gi]),
                .bout      (w_bout[gi])
            );
        end
    endgenerate

    // A carry or borrow out of the top digit means the whole count rolled over.
    logic r_wrap;
    always_ff @(posedge clkDiv190) begin
        if (rst) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_cout[NDIG-1] | w_bout[NDIG-1];
        end
    end
    assign wrap = r_wrap;

    // Per-digit blank flags for leading zeros.
    logic [NDIG-1:0] w_lz;
`ifdef LEADING_ZERO_BLANK_EN
    logic w_upper_zero;
    always_comb begin
        w_lz         = '0;
        w_upper_zero = 1'b1;
        for (int k = NDIG - 1; k >= 1; k--) begin
            w_upper_zero = w_upper_zero & (bcd[4*k +: 4] == 4'd0);
            w_lz[k]      = w_upper_zero;
        end
    end
`else
    assign w_lz = '0;
`endif

    // Select the digit under the scan index.
    logic [IW-1:0] r_idx;
    logic [3:0]    w_digit;
    logic          w_blank;
    always_comb begin
        w_digit = 4'd0;
        w_blank = 1'b0;
        for (int k = 0; k < NDIG; k++) begin
            if (r_idx == IW'(k)) begin
                w_digit = bcd[4*k +: 4];
                w_blank = w_lz[k];
            end
        end
    end

    logic [NDIG-1:0] w_onehot;
    logic [6:0]      w_seg_code;
    assign w_onehot   = NDIG'(1) << r_idx;
    assign w_seg_code = w_blank ? SEG_BLANK : seg_decode(w_digit);

    logic [NDIG-1:0] r_an;
    logic [6:0]      r_seg;
    always_ff @(posedge clkDiv190) begin
        if (rst) begin
            r_idx <= '0;
            r_an  <= {NDIG{SEG_ACT_LOW}};
            r_seg <= {7{SEG_ACT_LOW}};
        end else begin
            r_idx <= (r_idx == IW'(NDIG - 1)) ? '0 : r_idx + IW'(1);
            r_an  <= SEG_ACT_LOW ? ~w_onehot : w_onehot;
            r_seg <= SEG_ACT_LOW ? ~w_seg_code : w_seg_code;
        end
    end
    assign an  = r_an;
    assign seg = r_seg;

endmodule
